// File: rtl/rsa_ct_decryptor.sv
// Constant-time RSA decryption m = c^d mod n using a Montgomery ladder over shift-add modular multipliers.
// Optional operand range check is built when RSADEC_RANGE_CHECK_EN is defined.
module rsa_ct_decryptor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] c,
  input  logic [2*WIDTH-1:0] d,
  input  logic [2*WIDTH-1:0] n,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] m_out,
  output logic               err
);

  localparam int W2 = 2 * WIDTH;
  localparam int AW = W2 + 2;
  localparam int CW = $clog2(W2);
  localparam logic [CW-1:0] TOP = CW'(W2 - 1);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, UPD, DONE} state_t;

  state_t          state_q, state_d;
  logic [W2-1:0]   c_q, c_d, d_q, d_d, n_q, n_d;
  logic [W2-1:0]   r0_q, r0_d, r1_q, r1_d;
  logic [AW-1:0]   acc0_q, acc0_d, acc1_q, acc1_d;
  logic [CW-1:0]   bit_q, bit_d, k_q, k_d;
  logic            ready_q, ready_d, done_q, done_d;
  logic [W2-1:0]   m_out_q, m_out_d;
  logic [W2-1:0]   sq_s;
  logic            bad_s;

`ifdef RSADEC_RANGE_CHECK_EN
  logic err_flag_q, err_flag_d, err_q, err_d;
  assign bad_s = err_flag_q;
  assign err   = err_q;
`else
  assign bad_s = 1'b0;
  assign err   = 1'b0;
`endif

  // One MSB-first step: both trial subtractions are always formed, the result is only muxed.
  function automatic logic [AW-1:0] mod_step(input logic [AW-1:0] acc,
                                             input logic [W2-1:0] a,
                                             input logic          b,
                                             input logic [W2-1:0] nn);
    logic [AW-1:0] s, nx, res;
    logic [AW:0]   t1, t2;
    nx  = {2'b00, nn};
    s   = (acc << 1) + (b ? {2'b00, a} : {AW{1'b0}});
    t1  = {1'b0, s} - {1'b0, nx};
    t2  = {1'b0, s} - {1'b0, (nx << 1)};
    if (!t2[AW]) begin
      res = t2[AW-1:0];
    end else if (!t1[AW]) begin
      res = t1[AW-1:0];
    end else begin
      res = s;
    end
    return res;
  endfunction

  assign sq_s  = d_q[k_q] ? r1_q : r0_q;
  assign ready = ready_q;
  assign done  = done_q;
  assign m_out = m_out_q;

  // Next-state and datapath computation for the ladder sequencer.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    n_d     = n_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    bit_d   = bit_q;
    k_d     = k_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    m_out_d = m_out_q;
`ifdef RSADEC_RANGE_CHECK_EN
    err_flag_d = err_flag_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start && ready_q) begin
          c_d     = c;
          d_d     = d;
          n_d     = n;
          ready_d = 1'b0;
          state_d = LOAD;
`ifdef RSADEC_RANGE_CHECK_EN
          err_flag_d = (n < W2'(2)) || (c >= n);
`endif
        end else begin
          ready_d = 1'b1;
        end
      end
      LOAD: begin
        r0_d    = W2'(1);
        r1_d    = c_q;
        k_d     = TOP;
        bit_d   = TOP;
        acc0_d  = {AW{1'b0}};
        acc1_d  = {AW{1'b0}};
        state_d = MUL;
      end
      MUL: begin
        acc0_d = mod_step(acc0_q, r0_q, r1_q[bit_q], n_q);
        acc1_d = mod_step(acc1_q, sq_s, sq_s[bit_q], n_q);
        if (bit_q == {CW{1'b0}}) begin
          state_d = UPD;
        end else begin
          bit_d = bit_q - CW'(1);
        end
      end
      UPD: begin
        // acc0 holds the cross product R0*R1, acc1 the square of the selected register.
        if (d_q[k_q]) begin
          r0_d = acc0_q[W2-1:0];
          r1_d = acc1_q[W2-1:0];
        end else begin
          r1_d = acc0_q[W2-1:0];
          r0_d = acc1_q[W2-1:0];
        end
        acc0_d = {AW{1'b0}};
        acc1_d = {AW{1'b0}};
        bit_d  = TOP;
        if (k_q == {CW{1'b0}}) begin
          state_d = DONE;
        end else begin
          k_d     = k_q - CW'(1);
          state_d = MUL;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        m_out_d = bad_s ? {W2{1'b0}} : r0_q;
`ifdef RSADEC_RANGE_CHECK_EN
        err_d = err_flag_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= {W2{1'b0}};
      d_q     <= {W2{1'b0}};
      n_q     <= {W2{1'b0}};
      r0_q    <= {W2{1'b0}};
      r1_q    <= {W2{1'b0}};
      acc0_q  <= {AW{1'b0}};
      acc1_q  <= {AW{1'b0}};
      bit_q   <= {CW{1'b0}};
      k_q     <= {CW{1'b0}};
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      m_out_q <= {W2{1'b0}};
`ifdef RSADEC_RANGE_CHECK_EN
      err_flag_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      n_q     <= n_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      bit_q   <= bit_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      m_out_q <= m_out_d;
`ifdef RSADEC_RANGE_CHECK_EN
      err_flag_q <= err_flag_d;
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_rsa_ct_decryptor.sv
// Self-checking bench for rsa_ct_decryptor against a plain-arithmetic modular exponentiation model.
module tb_rsa_ct_decryptor;

  localparam int LAT = 274;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] c = 16'd0, d = 16'd0, n = 16'd0;
  logic [15:0] c2 = 16'd0, d2 = 16'd0, n2 = 16'd0;
  logic        ready, done, err, ready2, done2, err2;
  logic [15:0] m_out, m_out2;

  int tests = 0;
  int fails = 0;

  rsa_ct_decryptor #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .c(c), .d(d), .n(n),
    .ready(ready), .done(done), .m_out(m_out), .err(err)
  );

  rsa_ct_decryptor #(.WIDTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .c(c2), .d(d2), .n(n2),
    .ready(ready2), .done(done2), .m_out(m_out2), .err(err2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_modexp(input logic [15:0] cc, input logic [15:0] dd,
                                             input logic [15:0] nn);
    longint unsigned r, b;
    r = 64'd1 % nn;
    b = cc % nn;
    for (int i = 0; i < 16; i++) begin
      if (dd[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] cc, input logic [15:0] dd, input logic [15:0] nn,
                        output int lat, output logic [15:0] mm, output logic ee);
    int g;
    g = 0;
    while (!ready && g < 20) begin
      tick();
      g++;
    end
    c = cc; d = dd; n = nn;
    c2 = cc; d2 = dd; n2 = nn;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
    mm = m_out;
    ee = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (m_out !== 16'd0) begin fails++; $display("FAIL reset_m got=%0d exp=0", m_out); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    logic [15:0] vc[4] = '{16'd2790, 16'd2790, 16'd2790, 16'd0};
    logic [15:0] vd[4] = '{16'd2753, 16'd1, 16'd0, 16'd2753};
    logic [15:0] vm[4] = '{16'd65, 16'd2790, 16'd1, 16'd0};
    int lat;
    logic [15:0] mm;
    logic ee;
    for (int i = 0; i < 4; i++) begin
      run_op(vc[i], vd[i], 16'd3233, lat, mm, ee);
      tests++; if (lat != LAT) begin fails++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      tests++; if (mm !== vm[i]) begin fails++; $display("FAIL vec%0d_m got=%0d exp=%0d", i, mm, vm[i]); end
      tests++; if (ee !== 1'b0) begin fails++; $display("FAIL vec%0d_err got=%b exp=0", i, ee); end
      tick();
      tests++; if (done !== 1'b0 || ready !== 1'b1) begin
        fails++; $display("FAIL vec%0d_after_done done=%b ready=%b exp done=0 ready=1", i, done, ready);
      end
      tests++; if (m_out !== vm[i]) begin fails++; $display("FAIL vec%0d_m_hold got=%0d exp=%0d", i, m_out, vm[i]); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] mm, rn, rc, rd, exp_m;
    logic ee;
    for (int i = 0; i < 6; i++) begin
      rn = 16'($urandom_range(65535, 2));
      rc = 16'($urandom_range(32'(rn) - 1, 0));
      rd = 16'($urandom);
      exp_m = ref_modexp(rc, rd, rn);
      run_op(rc, rd, rn, lat, mm, ee);
      tests++; if (lat != LAT) begin fails++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      tests++; if (mm !== exp_m) begin
        fails++; $display("FAIL rand%0d_m c=%0d d=%0d n=%0d got=%0d exp=%0d", i, rc, rd, rn, mm, exp_m);
      end
      tick();
    end
  endtask

  task automatic test_constant_time();
    int seen;
    logic [15:0] exp1, exp2;
    exp1 = ref_modexp(16'd123, 16'hFFFF, 16'd3233);
    exp2 = ref_modexp(16'd123, 16'h0001, 16'd3233);
    c = 16'd123; d = 16'hFFFF; n = 16'd3233;
    c2 = 16'd123; d2 = 16'h0001; n2 = 16'd3233;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      tick();
      tests++; if (done !== done2 || ready !== ready2) begin
        fails++; $display("FAIL ct_lockstep cycle=%0d done=%b/%b ready=%b/%b", i, done, done2, ready, ready2);
      end
      if (done && seen == 0) begin
        seen = i;
        tests++; if (m_out !== exp1) begin fails++; $display("FAIL ct_m1 got=%0d exp=%0d", m_out, exp1); end
        tests++; if (m_out2 !== exp2) begin fails++; $display("FAIL ct_m2 got=%0d exp=%0d", m_out2, exp2); end
      end
    end
    tests++; if (seen != LAT) begin fails++; $display("FAIL ct_latency got=%0d exp=%0d", seen, LAT); end
  endtask

  task automatic test_range();
    int lat;
    logic [15:0] mm;
    logic ee;
    run_op(16'd4000, 16'd2753, 16'd3233, lat, mm, ee);
    tests++; if (lat != LAT) begin fails++; $display("FAIL range_c_latency got=%0d exp=%0d", lat, LAT); end
`ifdef RSADEC_RANGE_CHECK_EN
    tests++; if (ee !== 1'b1) begin fails++; $display("FAIL range_c_err got=%b exp=1", ee); end
    tests++; if (mm !== 16'd0) begin fails++; $display("FAIL range_c_m got=%0d exp=0", mm); end
`else
    tests++; if (ee !== 1'b0) begin fails++; $display("FAIL range_c_err got=%b exp=0", ee); end
`endif
    tick();
    run_op(16'd0, 16'd5, 16'd1, lat, mm, ee);
    tests++; if (lat != LAT) begin fails++; $display("FAIL range_n_latency got=%0d exp=%0d", lat, LAT); end
`ifdef RSADEC_RANGE_CHECK_EN
    tests++; if (ee !== 1'b1) begin fails++; $display("FAIL range_n_err got=%b exp=1", ee); end
    tests++; if (mm !== 16'd0) begin fails++; $display("FAIL range_n_m got=%0d exp=0", mm); end
`else
    tests++; if (ee !== 1'b0) begin fails++; $display("FAIL range_n_err got=%b exp=0", ee); end
`endif
    tick();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [15:0] mm, exp_m;
    logic ee;
    c = 16'd2790; d = 16'd2753; n = 16'd3233;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    rst = 1'b1;
    tick();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done got=%b exp=0", done); end
    tests++; if (m_out !== 16'd0) begin fails++; $display("FAIL midrst_m got=%0d exp=0", m_out); end
    rst = 1'b0;
    exp_m = ref_modexp(16'd1234, 16'd777, 16'd3233);
    run_op(16'd1234, 16'd777, 16'd3233, lat, mm, ee);
    tests++; if (lat != LAT) begin fails++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); end
    tests++; if (mm !== exp_m) begin fails++; $display("FAIL midrst_m_after got=%0d exp=%0d", mm, exp_m); end
    tick();
  endtask

  task automatic test_busy_start();
    int pulses, first;
    logic [15:0] exp_m;
    exp_m = ref_modexp(16'd2790, 16'd2753, 16'd3233);
    c = 16'd2790; d = 16'd2753; n = 16'd3233;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 300; i++) begin
      if (i == 1 || i == 50 || i == 273) begin
        c = 16'($urandom); d = 16'($urandom); n = 16'd4001;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
    tests++; if (first != LAT) begin fails++; $display("FAIL busy_latency got=%0d exp=%0d", first, LAT); end
    tests++; if (m_out !== exp_m) begin fails++; $display("FAIL busy_m got=%0d exp=%0d", m_out, exp_m); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] mm, exp_m;
    logic ee;
    run_op(16'd2790, 16'd2753, 16'd3233, lat, mm, ee);
    c = 16'd65; d = 16'd17; n = 16'd3233;
    c2 = 16'd65; d2 = 16'd17; n2 = 16'd3233;
    exp_m = ref_modexp(16'd65, 16'd17, 16'd3233);
    start = 1'b1;
    tick();
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", ready); end
    tick();
    start = 1'b0;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_accept got=%b exp=0", ready); end
    lat = 0;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
    tests++; if (lat != LAT) begin fails++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
    tests++; if (m_out !== exp_m) begin fails++; $display("FAIL b2b_m got=%0d exp=%0d", m_out, exp_m); end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_constant_time();
    test_range();
    test_reset_midop();
    test_busy_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
